// File: rtl/rgb_matrix_marquee_pkg.sv
// Shared definitions for the RGB matrix marquee.
//   mode_t       : motion mode encoding (2 bits)
//   COLOR_R/G/B  : bit positions of each channel inside the 3-bit colour word
//   COLOR_RESET  : colour selected out of reset (red)
//   next_mode()  : cyclic mode advance LEFT->RIGHT->BOUNCE->DIAG->LEFT
//   cnt_width()  : register width able to hold 0..div-1 (never below 1 bit)
package marquee_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_DIAG   = 2'd3
    } mode_t;

    localparam int COLOR_R = 0;
    localparam int COLOR_G = 1;
    localparam int COLOR_B = 2;

    localparam logic [2:0] COLOR_RESET = 3'd1;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/rgb_matrix_marquee_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, level debouncer and press detector.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous reset, active-low
//   btn_n  in  raw button, active-low, asynchronous to clk
//   level  out debounced level, 1 = held
//   press  out one-cycle pulse when the debounced level goes released->held
module btn_debounce
    import marquee_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    // Counter must be able to reach DEBOUNCE_CYCLES itself.
    localparam int CW = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic          pressed_sync;

    assign pressed_sync = ~sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Synchroniser starts at the released (high) level so no phantom press follows reset.
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (pressed_sync == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                level_reg <= pressed_sync;
                press_reg <= pressed_sync;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/rgb_matrix_marquee.sv
// RGB LED-matrix marquee: scans the rows one at a time and moves a single lit column across
// the matrix. The colour button cycles the 3-bit colour, the mode button cycles the motion
// mode (left, right, bounce, diagonal).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   btn_color  in   raw colour button, active-low, asynchronous
//   btn_mode   in   raw mode button, active-low, asynchronous
//   led        out  [0] step heartbeat, [1] either debounced button held
//   led_row    out  one-hot row select, active-high
//   led_col_r  out  red column drive, active-low
//   led_col_g  out  green column drive, active-low
//   led_col_b  out  blue column drive, active-low
module rgb_matrix_marquee
    import marquee_pkg::*;
#(
    parameter int ROWS            = 8,
    parameter int COLS            = 8,
    parameter int STEP_DIV        = 25_000_000,
    parameter int SCAN_DIV        = 6_250,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_color,
    input  logic            btn_mode,
    output logic [1:0]      led,
    output logic [ROWS-1:0] led_row,
    output logic [COLS-1:0] led_col_r,
    output logic [COLS-1:0] led_col_g,
    output logic [COLS-1:0] led_col_b
);

    localparam int PW = cnt_width(COLS);
    localparam int RW = cnt_width(ROWS);
    localparam int SW = cnt_width(STEP_DIV);
    localparam int CW = cnt_width(SCAN_DIV);

    localparam logic [PW-1:0]   POS_LAST   = PW'(COLS - 1);
    localparam logic [PW-1:0]   POS_PENULT = PW'(COLS - 2);
    localparam logic [PW-1:0]   POS_ONE    = PW'(1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [RW-1:0]   RIDX_ONE   = RW'(1);
    localparam logic [SW-1:0]   STEP_LAST  = SW'(STEP_DIV - 1);
    localparam logic [SW-1:0]   STEP_ONE   = SW'(1);
    localparam logic [CW-1:0]   SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   SCAN_ONE   = CW'(1);
    localparam logic [ROWS-1:0] ROW_ONE    = ROWS'(1);
    localparam logic [COLS-1:0] COL_ONE    = COLS'(1);

    logic level_color;
    logic press_color;
    logic level_mode;
    logic press_mode;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_color (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_color),
        .level (level_color),
        .press (press_color)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_mode),
        .level (level_mode),
        .press (press_mode)
    );

    mode_t           mode_reg;
    logic [2:0]      color_reg;
    logic [PW-1:0]   pos_reg;
    logic [PW-1:0]   pos_next;
    logic            dir_up_reg;
    logic            dir_up_next;
    logic [SW-1:0]   step_cnt_reg;
    logic            heartbeat_reg;
    logic [CW-1:0]   scan_cnt_reg;
    logic [RW-1:0]   row_idx_reg;
    logic            led1_reg;
    logic [ROWS-1:0] led_row_reg;
    logic [COLS-1:0] led_col_r_reg;
    logic [COLS-1:0] led_col_g_reg;
    logic [COLS-1:0] led_col_b_reg;

    logic step_tick;
    assign step_tick = (step_cnt_reg == STEP_LAST);

    // Next column position. A mode press restarts the pattern and wins over a step tick.
    always_comb begin
        pos_next    = pos_reg;
        dir_up_next = dir_up_reg;
        if (press_mode) begin
            pos_next    = '0;
            dir_up_next = 1'b1;
        end else if (step_tick) begin
            case (mode_reg)
                MODE_RIGHT: pos_next = (pos_reg == '0) ? POS_LAST : pos_reg - POS_ONE;
                MODE_BOUNCE: begin
                    // Turn around at either end so each end column is shown exactly once.
                    if (dir_up_reg) begin
                        if (pos_reg == POS_LAST) begin
                            dir_up_next = 1'b0;
                            pos_next    = POS_PENULT;
                        end else begin
                            pos_next = pos_reg + POS_ONE;
                        end
                    end else begin
                        if (pos_reg == '0) begin
                            dir_up_next = 1'b1;
                            pos_next    = POS_ONE;
                        end else begin
                            pos_next = pos_reg - POS_ONE;
                        end
                    end
                end
                default: pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_ONE;
            endcase
        end
    end

    // Lit column for the row currently being scanned; DIAG skews it by the row index.
    logic [31:0]     col_idx;
    logic [COLS-1:0] col_mask;
    always_comb begin
        col_idx = 32'(pos_reg);
        if (mode_reg == MODE_DIAG) begin
            col_idx = (32'(pos_reg) + 32'(row_idx_reg)) % 32'(COLS);
        end
        col_mask = COL_ONE << col_idx;
    end

    logic [COLS-1:0] col_drive [3];
    for (genvar gi = 0; gi < 3; gi++) begin : g_color
        assign col_drive[gi] = ~(col_mask & {COLS{color_reg[gi]}});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_reg      <= MODE_LEFT;
            color_reg     <= COLOR_RESET;
            pos_reg       <= '0;
            dir_up_reg    <= 1'b1;
            step_cnt_reg  <= '0;
            heartbeat_reg <= 1'b0;
            scan_cnt_reg  <= '0;
            row_idx_reg   <= '0;
            led1_reg      <= 1'b0;
            led_row_reg   <= ROW_ONE;
            led_col_r_reg <= '1;
            led_col_g_reg <= '1;
            led_col_b_reg <= '1;
        end else begin
            // The heartbeat follows the step counter even when a mode press cancels the move.
            if (step_tick) begin
                heartbeat_reg <= ~heartbeat_reg;
            end
            if (press_mode) begin
                mode_reg     <= next_mode(mode_reg);
                step_cnt_reg <= '0;
            end else if (step_tick) begin
                step_cnt_reg <= '0;
            end else begin
                step_cnt_reg <= step_cnt_reg + STEP_ONE;
            end
            if (press_color) begin
                color_reg <= color_reg + 3'd1;
            end
            pos_reg    <= pos_next;
            dir_up_reg <= dir_up_next;

            if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg <= '0;
                row_idx_reg  <= (row_idx_reg == ROW_LAST) ? '0 : row_idx_reg + RIDX_ONE;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + SCAN_ONE;
            end

            // Row select and column drives both come from the same row index, so they
            // always change together.
            led_row_reg   <= ROW_ONE << row_idx_reg;
            led_col_r_reg <= col_drive[COLOR_R];
            led_col_g_reg <= col_drive[COLOR_G];
            led_col_b_reg <= col_drive[COLOR_B];
            led1_reg      <= level_color | level_mode;
        end
    end

    assign led       = {led1_reg, heartbeat_reg};
    assign led_row   = led_row_reg;
    assign led_col_r = led_col_r_reg;
    assign led_col_g = led_col_g_reg;
    assign led_col_b = led_col_b_reg;

endmodule
